// File: rtl/out_fifo_pkg.sv
// Shared types and constants for the OUT_FIFO write-side packer (8x4 array mode).
package out_fifo_pkg;

    localparam int LANES  = 10;
    localparam int NIB_W  = 4;
    localparam int BYTE_W = 8;

    typedef logic [LANES*NIB_W-1:0]  nib_beat_t;
    typedef logic [LANES*BYTE_W-1:0] byte_word_t;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pack_state_t;

    // First beat lands in the low nibble so the read side unpacks in arrival order.
    function automatic byte_word_t pack_nibbles(input nib_beat_t lo, input nib_beat_t hi);
        byte_word_t w;
        w = '0;
        for (int k = 0; k < LANES; k++) begin
            w[k*BYTE_W +: BYTE_W] = {hi[k*NIB_W +: NIB_W], lo[k*NIB_W +: NIB_W]};
        end
        return w;
    endfunction

endpackage

// File: rtl/out_fifo_wr_skid.sv
// Two-entry in-order buffer between the nibble packer and OUT_FIFO; head entry is a register output.
module out_fifo_wr_skid #(
    parameter int W = 80
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push_i;
        rd_ptr_d = rd_ptr_q ^ pop_i;
        count_d  = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/out_fifo_wr_packer.sv
// Packs pairs of 10-lane nibble beats into OUT_FIFO byte words under FULL/ALMOSTFULL backpressure.
// Define OUT_FIFO_WR_STATS_EN to add the WR_COUNT / STALL_COUNT statistics outputs.
module out_fifo_wr_packer #(
    parameter int         LANES           = 10,
    parameter logic [3:0] IDLE_NIBBLE     = 4'h0,
    parameter bit         USE_ALMOST_FULL = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [LANES*4-1:0]   IN_DATA,
    input  logic                 FLUSH,
    input  logic                 FIFO_FULL,
    input  logic                 FIFO_ALMOSTFULL,
    output logic                 FIFO_WREN,
    output logic [LANES*8-1:0]   FIFO_D,
    output logic                 IDLE
`ifdef OUT_FIFO_WR_STATS_EN
    ,
    output logic [31:0]          WR_COUNT,
    output logic [31:0]          STALL_COUNT
`endif
);
    import out_fifo_pkg::*;

    pack_state_t state_q, state_d;
    nib_beat_t   lo_q, lo_d;
    logic        flush_pend_q, flush_pend_d;
    logic        rst_done_q;
    logic [1:0]  count;
    logic        accept, allow, push, pop;
    byte_word_t  push_word, head;

    assign allow     = !FIFO_FULL && !(USE_ALMOST_FULL && FIFO_ALMOSTFULL);
    assign IN_READY  = rst_done_q && (count < 2'd2);
    assign accept    = IN_VALID && IN_READY;
    assign pop       = (count != 2'd0) && allow;
    assign FIFO_WREN = pop;
    assign FIFO_D    = head;
    assign IDLE      = (state_q == EMPTY) && (count == 2'd0) && !flush_pend_q;

    always_comb begin
        state_d      = state_q;
        lo_d         = lo_q;
        flush_pend_d = flush_pend_q;
        push         = 1'b0;
        push_word    = pack_nibbles(lo_q, IN_DATA);
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = HALF;
                    lo_d    = IN_DATA;
                end
            end
            HALF: begin
                // A real second beat always wins over a pending pad.
                if (accept) begin
                    state_d      = EMPTY;
                    push         = 1'b1;
                    flush_pend_d = 1'b0;
                end else if (flush_pend_q && (count < 2'd2)) begin
                    state_d      = EMPTY;
                    push         = 1'b1;
                    push_word    = pack_nibbles(lo_q, nib_beat_t'({LANES{IDLE_NIBBLE}}));
                    flush_pend_d = 1'b0;
                end else if (FLUSH) begin
                    flush_pend_d = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= EMPTY;
            lo_q         <= '0;
            flush_pend_q <= 1'b0;
            rst_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lo_q         <= lo_d;
            flush_pend_q <= flush_pend_d;
            rst_done_q   <= 1'b1;
        end
    end

    out_fifo_wr_skid #(.W(LANES*8)) u_skid (
        .clk_i   (CLK),
        .rst_n_i (RESET_N),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (push_word),
        .dout_o  (head),
        .count_o (count)
    );

`ifdef OUT_FIFO_WR_STATS_EN
    logic [31:0] wr_count_q, stall_count_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_count_q    <= '0;
            stall_count_q <= '0;
        end else begin
            if (pop && (wr_count_q != 32'hFFFF_FFFF)) begin
                wr_count_q <= wr_count_q + 32'd1;
            end
            if ((count != 2'd0) && !allow && (stall_count_q != 32'hFFFF_FFFF)) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign WR_COUNT    = wr_count_q;
    assign STALL_COUNT = stall_count_q;
`endif

endmodule

// File: tb/tb_out_fifo_wr_packer.sv
// Directed bench for out_fifo_wr_packer: a per-cycle vector table plus backpressure/reset sequences.
module tb_out_fifo_wr_packer;

    logic        clk, rst_n, in_valid, flush, full, afull;
    logic [39:0] in_data;
    logic        in_ready, wren, idle;
    logic [79:0] d;
    logic        n_ready, n_wren, n_idle;
    logic [79:0] n_d;
`ifdef OUT_FIFO_WR_STATS_EN
    logic [31:0] wr_count, stall_count, n_wr_count, n_stall_count;
`endif

    int tests = 0;
    int fails = 0;

    out_fifo_wr_packer #(.IDLE_NIBBLE(4'hA), .USE_ALMOST_FULL(1'b1)) dut (
        .CLK(clk), .RESET_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
        .IN_DATA(in_data), .FLUSH(flush), .FIFO_FULL(full), .FIFO_ALMOSTFULL(afull),
        .FIFO_WREN(wren), .FIFO_D(d), .IDLE(idle)
`ifdef OUT_FIFO_WR_STATS_EN
        , .WR_COUNT(wr_count), .STALL_COUNT(stall_count)
`endif
    );

    out_fifo_wr_packer #(.IDLE_NIBBLE(4'hA), .USE_ALMOST_FULL(1'b0)) u_noaf (
        .CLK(clk), .RESET_N(rst_n), .IN_VALID(in_valid), .IN_READY(n_ready),
        .IN_DATA(in_data), .FLUSH(flush), .FIFO_FULL(full), .FIFO_ALMOSTFULL(afull),
        .FIFO_WREN(n_wren), .FIFO_D(n_d), .IDLE(n_idle)
`ifdef OUT_FIFO_WR_STATS_EN
        , .WR_COUNT(n_wr_count), .STALL_COUNT(n_stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [79:0] pack(input logic [39:0] lo, input logic [39:0] hi);
        logic [79:0] w;
        w = '0;
        for (int k = 0; k < 10; k++) w[8*k +: 8] = {hi[4*k +: 4], lo[4*k +: 4]};
        return w;
    endfunction

    typedef struct {
        logic        v;
        logic [39:0] data;
        logic        fl;
        logic        ready;
        logic        wren;
        logic        chk_d;
        logic [79:0] d;
        logic        idle;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [39:0] data, input logic fl,
                                input logic ready, input logic wr, input logic chk_d,
                                input logic [79:0] dd, input logic idl);
        vec_t r;
        r.v = v; r.data = data; r.fl = fl; r.ready = ready;
        r.wren = wr; r.chk_d = chk_d; r.d = dd; r.idle = idl;
        return r;
    endfunction

    localparam logic [79:0] W1   = 80'hF0E1D2C3B4A596877869;
    localparam logic [79:0] WPAD = {10{8'hA1}};
    localparam logic [79:0] W32  = {10{8'h32}};

    vec_t         vecs[16];
    logic [39:0]  b3[6];
    logic [39:0]  s8[8];
    logic [79:0]  got[$];
    int           idx;
    logic         acc, wren_bad, ready_drop;

    initial begin
        vecs[0]  = mk(1, 40'h0123456789, 0, 1, 0, 0, '0,   1);
        vecs[1]  = mk(1, 40'hFEDCBA9876, 0, 1, 0, 0, '0,   0);
        vecs[2]  = mk(0, 40'h0,          0, 1, 1, 1, W1,   0);
        vecs[3]  = mk(1, 40'h1111111111, 0, 1, 0, 0, '0,   1);
        vecs[4]  = mk(0, 40'h0,          1, 1, 0, 0, '0,   0);
        vecs[5]  = mk(0, 40'h0,          0, 1, 0, 0, '0,   0);
        vecs[6]  = mk(0, 40'h0,          0, 1, 1, 1, WPAD, 0);
        vecs[7]  = mk(0, 40'h0,          0, 1, 0, 0, '0,   1);
        vecs[8]  = mk(0, 40'h0,          1, 1, 0, 0, '0,   1);
        vecs[9]  = mk(0, 40'h0,          0, 1, 0, 0, '0,   1);
        vecs[10] = mk(1, 40'h2222222222, 0, 1, 0, 0, '0,   1);
        vecs[11] = mk(0, 40'h0,          1, 1, 0, 0, '0,   0);
        vecs[12] = mk(1, 40'h3333333333, 0, 1, 0, 0, '0,   0);
        vecs[13] = mk(0, 40'h0,          0, 1, 1, 1, W32,  0);
        vecs[14] = mk(0, 40'h0,          0, 1, 0, 0, '0,   1);
        vecs[15] = mk(0, 40'h0,          0, 1, 0, 0, '0,   1);
        b3 = '{40'h0A1B2C3D4E, 40'h5F60718293, 40'hA4B5C6D7E8, 40'hF901234567, 40'h89ABCDEF01, 40'h2468ACE135};

        rst_n = 1'b1; in_valid = 0; in_data = '0; flush = 0; full = 0; afull = 0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", in_ready, 0);
        check("rst_wren", wren, 0);
        check("rst_d", d, '0);
        check("rst_idle", idle, 1);
        next(); next();
        rst_n = 1'b1;
        #1;
        check("rel_ready_before_edge", in_ready, 0);
        next();
        check("rel_ready_after_edge", in_ready, 1);

        // Per-cycle table: pack, latency, flush pad, flush ignored in EMPTY, accept beats pending pad.
        for (int i = 0; i < 16; i++) begin
            in_valid = vecs[i].v; in_data = vecs[i].data; flush = vecs[i].fl;
            #1;
            check($sformatf("vec%0d_ready", i), in_ready, vecs[i].ready);
            check($sformatf("vec%0d_wren", i), wren, vecs[i].wren);
            check($sformatf("vec%0d_idle", i), idle, vecs[i].idle);
            if (vecs[i].chk_d) check($sformatf("vec%0d_d", i), d, vecs[i].d);
            next();
        end
        in_valid = 0; flush = 0;

        // FIFO_FULL held while beats stream in, then released to drain.
        full = 1; idx = 0; wren_bad = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (idx < 6); in_data = (idx < 6) ? b3[idx] : '0;
            #1;
            if (wren) wren_bad = 1;
            acc = in_valid && in_ready;
            next();
            if (acc) idx++;
        end
        #1;
        check("full_no_wren", wren_bad, 0);
        check("full_beats_taken", idx, 4);
        check("full_ready_low", in_ready, 0);
        check("full_idle_low", idle, 0);
        full = 0; got.delete();
        for (int c = 0; c < 40 && (got.size() < 3 || idx < 6); c++) begin
            in_valid = (idx < 6); in_data = (idx < 6) ? b3[idx] : '0;
            #1;
            if (wren) got.push_back(d);
            acc = in_valid && in_ready;
            next();
            if (acc) idx++;
        end
        in_valid = 0;
        check("drain_word_count", got.size(), 3);
        for (int j = 0; j < 3 && j < got.size(); j++)
            check($sformatf("drain_word%0d", j), got[j], pack(b3[2*j], b3[2*j+1]));
        next();
        check("drain_idle", idle, 1);

        // Sustained stream with allow=1: ready never drops, one word per two beats.
        for (int i = 0; i < 8; i++) begin
            logic [3:0] n;
            n = 4'(i + 3);
            s8[i] = {10{n}};
        end
        idx = 0; ready_drop = 0; got.delete();
        for (int c = 0; c < 12; c++) begin
            in_valid = (idx < 8); in_data = (idx < 8) ? s8[idx] : '0;
            #1;
            if (in_valid && !in_ready) ready_drop = 1;
            if (wren) got.push_back(d);
            acc = in_valid && in_ready;
            next();
            if (acc) idx++;
        end
        in_valid = 0;
        check("stream_ready_held", ready_drop, 0);
        check("stream_word_count", got.size(), 4);
        for (int j = 0; j < 4 && j < got.size(); j++)
            check($sformatf("stream_word%0d", j), got[j], pack(s8[2*j], s8[2*j+1]));

        // ALMOSTFULL gates the main instance only.
        afull = 1;
        in_valid = 1; in_data = 40'h0123456789; #1; next();
        in_data = 40'hFEDCBA9876; #1; next();
        in_valid = 0; #1;
        check("af_main_wren", wren, 0);
        check("af_noaf_wren", n_wren, 1);
        check("af_noaf_d", n_d, W1);
        next();
        check("af_main_hold", wren, 0);
        check("af_main_busy", idle, 0);
        next();
        afull = 0; #1;
        check("af_release_wren", wren, 1);
        check("af_release_d", d, W1);
        next();
        check("af_after_idle", idle, 1);

        // Reset in HALF with a buffered word and a pending flush.
        full = 1;
        in_valid = 1; in_data = 40'h1234512345; #1; next();
        in_data = 40'h6789A6789A; #1; next();
        in_data = 40'hBCDEFBCDEF; #1; next();
        in_valid = 0; flush = 1; #1; next();
        flush = 0; #1;
        check("pre_rst_busy", idle, 0);
        full = 0; rst_n = 0; #1;
        check("midrst_wren", wren, 0);
        check("midrst_idle", idle, 1);
        check("midrst_ready", in_ready, 0);
        check("midrst_d", d, '0);
        next();
        rst_n = 1; #1;
        check("midrel_ready_before", in_ready, 0);
        next();
        check("midrel_ready_after", in_ready, 1);
        check("midrel_wren", wren, 0);
        check("midrel_idle", idle, 1);

`ifdef OUT_FIFO_WR_STATS_EN
        rst_n = 0; #1; next(); rst_n = 1; next();
        check("stats_reset_wr", wr_count, 0);
        check("stats_reset_stall", stall_count, 0);
        full = 1;
        in_valid = 1; in_data = 40'h0123456789; #1; next();
        in_data = 40'hFEDCBA9876; #1; next();
        in_valid = 0; #1; next();
        #1; next();
        #1; next();
        full = 0;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid = (idx < 6); in_data = (idx < 6) ? b3[idx] : '0;
            #1;
            acc = in_valid && in_ready;
            next();
            if (acc) idx++;
        end
        in_valid = 0;
        next(); next();
        check("stats_wr_count", wr_count, 4);
        check("stats_stall_count", stall_count, 3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
